// File: rtl/minirisc_acc_core.sv
// Multi-cycle accumulator core: one instruction per handshake, sequenced IDLE -> EXEC -> WB.
// EXEC stages the result and carry; WB commits the accumulator, flags, register file and output port.
module minirisc_acc_core #(
   parameter int DATA_W = 8,
   parameter int NREGS  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [3:0]        instr_op,
   input  logic [DATA_W-1:0] instr_arg,
   output logic [DATA_W-1:0] acc_out,
   output logic [1:0]        state_out,
   output logic              carry_out,
   output logic              zero_out,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   output logic              halted
);

   localparam int RI_W = (NREGS > 1) ? $clog2(NREGS) : 1;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_EXEC = 2'd1;
   localparam logic [1:0] S_WB   = 2'd2;
   localparam logic [1:0] S_HALT = 2'd3;

   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_ADD  = 4'h2;
   localparam logic [3:0] OP_ADDI = 4'h3;
   localparam logic [3:0] OP_SUB  = 4'h4;
   localparam logic [3:0] OP_AND  = 4'h5;
   localparam logic [3:0] OP_OR   = 4'h6;
   localparam logic [3:0] OP_XOR  = 4'h7;
   localparam logic [3:0] OP_ST   = 4'h8;
   localparam logic [3:0] OP_LD   = 4'h9;
   localparam logic [3:0] OP_SHL  = 4'hA;
   localparam logic [3:0] OP_SHR  = 4'hB;
   localparam logic [3:0] OP_OUT  = 4'hD;
   localparam logic [3:0] OP_HALT = 4'hF;

   logic [1:0]        state_q, state_d;
   logic [3:0]        op_q, op_d;
   logic [DATA_W-1:0] arg_q, arg_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic              carry_q, carry_d;
   logic              zero_q, zero_d;
   logic [DATA_W-1:0] res_q, res_d;
   logic              res_c_q, res_c_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;
   logic [DATA_W-1:0] rf_q [NREGS];
   logic [DATA_W-1:0] rf_d [NREGS];

   logic [RI_W-1:0]   ri;
   logic [DATA_W-1:0] rd_val;
   logic [DATA_W:0]   sum_reg, sum_imm, diff_reg;
   logic              wr_acc, wr_carry;

   assign ri       = arg_q[RI_W-1:0];
   assign rd_val   = rf_q[ri];
   assign sum_reg  = {1'b0, acc_q} + {1'b0, rd_val};
   assign sum_imm  = {1'b0, acc_q} + {1'b0, arg_q};
   // The extra top bit of the widened difference is the borrow.
   assign diff_reg = {1'b0, acc_q} - {1'b0, rd_val};

   always_comb begin
      wr_acc   = 1'b0;
      wr_carry = 1'b0;
      case (op_q)
         OP_LDI, OP_LD:  wr_acc = 1'b1;
         OP_ADD, OP_ADDI, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
            wr_acc   = 1'b1;
            wr_carry = 1'b1;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      arg_d       = arg_q;
      acc_d       = acc_q;
      carry_d     = carry_q;
      zero_d      = zero_q;
      res_d       = res_q;
      res_c_d     = res_c_q;
      out_data_d  = out_data_q;
      out_valid_d = 1'b0;
      for (int i = 0; i < NREGS; i++) begin
         rf_d[i] = rf_q[i];
      end

      case (state_q)
         S_IDLE: begin
            if (instr_valid) begin
               op_d    = instr_op;
               arg_d   = instr_arg;
               state_d = S_EXEC;
            end
         end
         S_EXEC: begin
            res_d   = acc_q;
            res_c_d = carry_q;
            case (op_q)
               OP_LDI:  res_d = arg_q;
               OP_ADD:  {res_c_d, res_d} = sum_reg;
               OP_ADDI: {res_c_d, res_d} = sum_imm;
               OP_SUB:  {res_c_d, res_d} = diff_reg;
               OP_AND:  begin res_d = acc_q & rd_val; res_c_d = 1'b0; end
               OP_OR:   begin res_d = acc_q | rd_val; res_c_d = 1'b0; end
               OP_XOR:  begin res_d = acc_q ^ rd_val; res_c_d = 1'b0; end
               OP_LD:   res_d = rd_val;
               OP_SHL:  begin res_d = {acc_q[DATA_W-2:0], 1'b0}; res_c_d = acc_q[DATA_W-1]; end
               OP_SHR:  begin res_d = {1'b0, acc_q[DATA_W-1:1]}; res_c_d = acc_q[0]; end
               default: ;
            endcase
            state_d = S_WB;
         end
         S_WB: begin
            if (wr_acc) begin
               acc_d  = res_q;
               zero_d = (res_q == '0);
            end
            if (wr_carry) begin
               carry_d = res_c_q;
            end
            if (op_q == OP_ST) begin
               rf_d[ri] = acc_q;
            end
            if (op_q == OP_OUT) begin
               out_data_d  = acc_q;
               out_valid_d = 1'b1;
            end
            state_d = (op_q == OP_HALT) ? S_HALT : S_IDLE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         op_q        <= '0;
         arg_q       <= '0;
         acc_q       <= '0;
         carry_q     <= 1'b0;
         zero_q      <= 1'b0;
         res_q       <= '0;
         res_c_q     <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         arg_q       <= arg_d;
         acc_q       <= acc_d;
         carry_q     <= carry_d;
         zero_q      <= zero_d;
         res_q       <= res_d;
         res_c_q     <= res_c_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         for (int i = 0; i < NREGS; i++) begin
            rf_q[i] <= rf_d[i];
         end
      end
   end

   assign instr_ready = (state_q == S_IDLE);
   assign halted      = (state_q == S_HALT);
   assign state_out   = state_q;
   assign acc_out     = acc_q;
   assign carry_out   = carry_q;
   assign zero_out    = zero_q;
   assign out_valid   = out_valid_q;
   assign out_data    = out_data_q;

endmodule

// File: tb/tb_minirisc_acc_core.sv
// Directed bench for minirisc_acc_core: expected commits are queued at issue time and
// checked by an independent monitor when the core leaves WB.
module tb_minirisc_acc_core;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       instr_valid = 1'b0;
   logic       instr_ready;
   logic [3:0] instr_op = 4'h0;
   logic [7:0] instr_arg = 8'h00;
   logic [7:0] acc_out;
   logic [1:0] state_out;
   logic       carry_out, zero_out, out_valid, halted;
   logic [7:0] out_data;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   logic [9:0] exp_q [$];
   logic [7:0] out_q [$];

   minirisc_acc_core #(.DATA_W(8), .NREGS(4)) dut (
      .clk(clk), .rst(rst),
      .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr_op(instr_op), .instr_arg(instr_arg),
      .acc_out(acc_out), .state_out(state_out),
      .carry_out(carry_out), .zero_out(zero_out),
      .out_valid(out_valid), .out_data(out_data),
      .halted(halted)
   );

   always #5 clk = ~clk;

   initial forever begin
      @(negedge clk);
      cyc = cyc + 1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Commit and output-port monitor, sampling on the falling edge.
   initial begin
      logic [1:0] st_prev;
      logic [9:0] e;
      logic [7:0] eo;
      st_prev = 2'd0;
      forever begin
         @(negedge clk);
         if (!rst && st_prev == 2'd2 && state_out != 2'd2) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL commit: unexpected commit acc=%h", acc_out);
            end else begin
               e = exp_q.pop_front();
               $display("commit acc=%h c=%b z=%b (want %h %b %b)", acc_out, carry_out, zero_out,
                        e[9:2], e[1], e[0]);
               if ({acc_out, carry_out, zero_out} !== e) begin
                  n_err++;
                  $display("FAIL commit: got acc=%h c=%b z=%b expected acc=%h c=%b z=%b",
                           acc_out, carry_out, zero_out, e[9:2], e[1], e[0]);
               end
            end
         end
         if (out_valid) begin
            n_vec++;
            if (out_q.size() == 0) begin
               n_err++;
               $display("FAIL out_port: unexpected out_valid data=%h", out_data);
            end else begin
               eo = out_q.pop_front();
               $display("out_port data=%h (want %h)", out_data, eo);
               if (out_data !== eo) begin
                  n_err++;
                  $display("FAIL out_port: got %h expected %h", out_data, eo);
               end
            end
         end
         st_prev = state_out;
      end
   end

   task automatic send(input logic [3:0] op, input logic [7:0] arg, input bit keep, input bit chk,
                       input logic [7:0] ea, input logic ec, input logic ez, output int acc_cyc);
      int g;
      g = 0;
      acc_cyc = -1;
      @(negedge clk); #1;
      instr_valid = 1'b1;
      instr_op    = op;
      instr_arg   = arg;
      while (!instr_ready && g < 20) begin
         @(negedge clk); #1;
         g++;
      end
      if (!instr_ready) begin
         n_vec++;
         n_err++;
         $display("FAIL accept_timeout: op=%h never accepted", op);
         instr_valid = 1'b0;
         return;
      end
      @(posedge clk);
      if (chk) exp_q.push_back({ea, ec, ez});
      if (chk && op == 4'hD) out_q.push_back(ea);
      @(negedge clk); #1;
      acc_cyc = cyc;
      if (!keep) instr_valid = 1'b0;
   endtask

   task automatic vec(input logic [3:0] op, input logic [7:0] arg,
                      input logic [7:0] ea, input logic ec, input logic ez);
      int c;
      send(op, arg, 1'b0, 1'b1, ea, ec, ez, c);
   endtask

   task automatic wait_idle();
      int g;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while ((state_out == 2'd1 || state_out == 2'd2) && g < 10);
      if (state_out == 2'd1 || state_out == 2'd2) begin
         n_vec++;
         n_err++;
         $display("FAIL idle_timeout: state stuck at %0d", state_out);
      end
   endtask

   initial begin
      int c_prev, c_now;

      // Reset held two cycles with a pending LDI; reset must win.
      instr_valid = 1'b1; instr_op = 4'h1; instr_arg = 8'hAA;
      repeat (2) @(negedge clk);
      check("rst_acc", acc_out, 8'h00);
      check("rst_state", state_out, 2'd0);
      check("rst_carry", carry_out, 1'b0);
      check("rst_zero", zero_out, 1'b0);
      check("rst_ready", instr_ready, 1'b1);
      check("rst_out_valid", out_valid, 1'b0);
      check("rst_halted", halted, 1'b0);
      #1 rst = 1'b0;
      @(posedge clk);
      exp_q.push_back({8'hAA, 1'b0, 1'b0});
      @(negedge clk);
      check("first_accept_state", state_out, 2'd1);
      #1 instr_valid = 1'b0;
      @(negedge clk);
      check("exec_to_wb_state", state_out, 2'd2);
      wait_idle();

      // Add with carry
      vec(4'h1, 8'hF0, 8'hF0, 1'b0, 1'b0);
      vec(4'h3, 8'h20, 8'h10, 1'b1, 1'b0);
      vec(4'h3, 8'hF0, 8'h00, 1'b1, 1'b1);

      // Registers and borrow
      vec(4'h1, 8'h10, 8'h10, 1'b1, 1'b0);
      vec(4'h8, 8'h02, 8'h10, 1'b1, 1'b0);
      vec(4'h1, 8'h01, 8'h01, 1'b1, 1'b0);
      vec(4'h4, 8'h02, 8'hF1, 1'b1, 1'b0);
      vec(4'h9, 8'h02, 8'h10, 1'b1, 1'b0);
      vec(4'h4, 8'h02, 8'h00, 1'b0, 1'b1);
      vec(4'h1, 8'h3C, 8'h3C, 1'b0, 1'b0);
      vec(4'h8, 8'h06, 8'h3C, 1'b0, 1'b0);
      vec(4'h1, 8'h00, 8'h00, 1'b0, 1'b1);
      vec(4'h9, 8'hFE, 8'h3C, 1'b0, 1'b0);

      // Shifts and logic ops (R2 = 3C)
      vec(4'h1, 8'h81, 8'h81, 1'b0, 1'b0);
      vec(4'hA, 8'h00, 8'h02, 1'b1, 1'b0);
      vec(4'hB, 8'h00, 8'h01, 1'b0, 1'b0);
      vec(4'hB, 8'h00, 8'h00, 1'b1, 1'b1);
      vec(4'h1, 8'h0F, 8'h0F, 1'b1, 1'b0);
      vec(4'h7, 8'h02, 8'h33, 1'b0, 1'b0);
      vec(4'h6, 8'h02, 8'h3F, 1'b0, 1'b0);
      vec(4'h5, 8'h02, 8'h3C, 1'b0, 1'b0);
      vec(4'h2, 8'h02, 8'h78, 1'b0, 1'b0);
      vec(4'h0, 8'h55, 8'h78, 1'b0, 1'b0);
      vec(4'hC, 8'h55, 8'h78, 1'b0, 1'b0);
      wait_idle();

      // Streaming with valid held high: one accept every 3 cycles
      c_prev = -1;
      for (int k = 1; k <= 9; k++) begin
         send(4'h1, 8'(k), 1'b1, 1'b1, 8'(k), 1'b0, 1'b0, c_now);
         if (c_prev >= 0) check("stream_interval", c_now - c_prev, 3);
         c_prev = c_now;
      end
      #1 instr_valid = 1'b0;
      wait_idle();
      repeat (4) @(negedge clk);
      check("valid_low_state", state_out, 2'd0);
      check("stream_final_acc", acc_out, 8'h09);

      // OUT and HALT
      vec(4'h1, 8'h5A, 8'h5A, 1'b0, 1'b0);
      vec(4'hD, 8'h00, 8'h5A, 1'b0, 1'b0);
      wait_idle();
      check("out_valid_high", out_valid, 1'b1);
      @(negedge clk);
      check("out_valid_one_cycle", out_valid, 1'b0);
      check("out_data_hold", out_data, 8'h5A);
      vec(4'hF, 8'h00, 8'h5A, 1'b0, 1'b0);
      wait_idle();
      check("halt_state", state_out, 2'd3);
      check("halt_flag", halted, 1'b1);
      check("halt_ready", instr_ready, 1'b0);
      #1 instr_valid = 1'b1; instr_op = 4'h1; instr_arg = 8'h77;
      repeat (6) @(negedge clk);
      check("halt_ignores_acc", acc_out, 8'h5A);
      check("halt_absorbing", state_out, 2'd3);
      #1 rst = 1'b1;
      @(negedge clk);
      check("halt_rst_state", state_out, 2'd0);
      check("halt_rst_acc", acc_out, 8'h00);
      #1 rst = 1'b0; instr_valid = 1'b0;

      // Reset during EXEC discards the instruction
      vec(4'h1, 8'h44, 8'h44, 1'b0, 1'b0);
      wait_idle();
      send(4'h1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, c_now);
      check("midop_in_exec", state_out, 2'd1);
      rst = 1'b1;
      @(negedge clk);
      check("rst_exec_acc", acc_out, 8'h00);
      check("rst_exec_state", state_out, 2'd0);
      #1 rst = 1'b0;

      // Reset during WB discards the instruction
      vec(4'h1, 8'h44, 8'h44, 1'b0, 1'b0);
      wait_idle();
      send(4'h1, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, c_now);
      @(negedge clk);
      check("midop_in_wb", state_out, 2'd2);
      #1 rst = 1'b1;
      @(negedge clk);
      check("rst_wb_acc", acc_out, 8'h00);
      check("rst_wb_state", state_out, 2'd0);
      check("rst_wb_zero", zero_out, 1'b0);
      #1 rst = 1'b0;

      repeat (4) @(negedge clk);
      check("pending_commits", exp_q.size(), 0);
      check("pending_outs", out_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/minirisc_acc_core.md
# minirisc_acc_core

Parametrised multi-cycle accumulator CPU core, the generalised successor of the 8-bit mini-RISC tile. It accepts one instruction per valid/ready handshake and executes it through a fixed IDLE→EXEC→WB sequence. It provides a configurable data width, an internal register file, carry/zero flags, an output port and a HALT state. It sits behind the tile wrapper, which maps pad inputs onto the instruction port and exposes `acc_out`/`state_out` for debug.

## Interface
- `DATA_W`, 8, accumulator, register and operand width; legal range 4..32.
- `NREGS`, 4, register-file depth; power of two, 2..16; index width `RI_W = log2(NREGS)`.
- `clk`  in  1  sole clock, all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high; one clock, `clk`.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  core can accept; high only in IDLE.
- `instr_op`  in  4  opcode.
- `instr_arg`  in  DATA_W  immediate, or register index in bits [RI_W-1:0]; upper bits ignored for register ops.
- `acc_out`  out  DATA_W  accumulator.
- `state_out`  out  2  0 IDLE, 1 EXEC, 2 WB, 3 HALT.
- `carry_out`, `zero_out`  out  1 each  flags.
- `out_valid`  out  1  one-cycle strobe from OUT.
- `out_data`  out  DATA_W  value registered by OUT; holds until next OUT.
- `halted`  out  1  high in HALT.

## Operation
- Opcodes: 0 NOP; 1 LDI acc=arg; 2 ADD acc+=R[i]; 3 ADDI acc+=arg; 4 SUB acc-=R[i]; 5 AND acc&=R[i]; 6 OR; 7 XOR; 8 ST R[i]=acc; 9 LD acc=R[i]; A SHL acc<<=1; B SHR acc>>=1 (logical); D OUT; F HALT. C, E execute as NOP.
- Arithmetic is modulo 2^DATA_W. ADD/ADDI: carry = bit DATA_W of the (DATA_W+1)-bit sum. SUB: carry = 1 iff borrow, i.e. acc < R[i] unsigned. SHL: carry = old MSB. SHR: carry = old LSB. AND/OR/XOR: carry = 0.
- Zero is set to (new acc == 0) on every acc-writing op: 1,2,3,4,5,6,7,9,A,B. LDI and LD leave carry unchanged. ST, NOP, OUT and HALT leave both flags unchanged.
- Handshake: a transfer occurs on a rising edge with `instr_valid & instr_ready`. Op and arg are latched; the inputs are don't-care afterwards. Valid low in IDLE keeps the core in IDLE.
- FSM:
  - IDLE→EXEC on transfer.
  - EXEC→WB always; EXEC computes the result, flags and target into internal registers.
  - WB→IDLE commits acc, register file, flags and out_data; for op F, WB→HALT instead.
  - HALT is absorbing until `rst`; `instr_ready` = 0 in HALT.
- OUT: in WB, out_data←acc and `out_valid` = 1 for exactly the cycle after the WB edge.
- Reset: acc, flags, out_data, all R[i], and latched op/arg clear to 0; state→IDLE; `out_valid` = 0, `halted` = 0, `instr_ready` = 1. Reset in any state, mid-instruction included, discards the in-flight instruction with no partial commit. Reset takes priority over a simultaneous handshake.

## Timing
- Transfer at edge T: state_out = 1 after T, 2 after T+1. Results are visible on acc_out/flags/R after T+2, and state_out = 0 (or 3 for HALT).
- `instr_ready` is high again after T+2. The next transfer can occur no earlier than edge T+3, so throughput is one instruction per 3 cycles.
- `out_valid` is high during the cycle between edges T+2 and T+3 only.
- All outputs are registered or decoded from registered state; no combinational input→output path except none. `instr_ready` depends only on state.

## Test plan
- Reset: hold `rst` 2 cycles with valid=1 → acc_out=00, state_out=0, carry=zero=0, instr_ready=1, out_valid=0. Release → the first transfer occurs on the next edge.
- Add with carry (DATA_W=8): LDI F0, ADDI 20 → acc=10, carry=1, zero=0. ADDI F0 → acc=00, carry=1, zero=1.
- Registers and borrow: LDI 10, ST R2, LDI 01, SUB R2 → acc=F1, carry=1. LD R2 → acc=10, carry still 1, zero=0. SUB R2 → acc=00, carry=0, zero=1. ST with arg=0x06 (NREGS=4) writes R2.
- Handshake cadence: hold valid=1 streaming LDI 1..9 → exactly one accept every 3 cycles, state sequence 0,1,2 repeating, final acc=09. Drop valid mid-stream → state stays 0.
- OUT/HALT: LDI 5A, OUT → out_valid high for exactly 1 cycle, out_data=5A. HALT → state_out=3, halted=1, instr_ready=0. Subsequent LDI 77 with valid=1 is ignored (acc=5A). Assert rst → state 0, acc 00.
- Reset mid-op: LDI 33 accepted, `rst` asserted in EXEC → after the reset edge, acc=00, state=0, no commit. Repeat with `rst` in WB → same result.
